// File: rtl/demux8_dispatch.sv
// demux8_dispatch: single-entry dispatcher from one valid/ready producer to eight consumers.
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_data/in_dest/mode producer side;
//   out_valid[8]/out_ready[8]/out_data/sel consumer side; busy, drop, drop_count status.
module demux8_dispatch #(
  parameter int DW      = 8,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic [2:0]    in_dest,
  input  logic          mode,
  output logic [7:0]    out_valid,
  input  logic [7:0]    out_ready,
  output logic [DW-1:0] out_data,
  output logic [2:0]    sel,
  output logic          busy,
  output logic          drop,
  output logic [7:0]    drop_count
);

  localparam int WCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WCW-1:0] LAST = WCW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t         state;
  logic [2:0]     rr_ptr;
  logic [WCW-1:0] wait_cnt;

  logic [2:0] rr_sel;
  logic [2:0] idx;
  logic       found;
  logic [2:0] nsel;
  logic       ready_sel;
  logic       cap;
  logic       done;
  logic       expire;
  logic       stall;
  logic       tmo;

  // First ready channel scanning upward from rr_ptr; rr_ptr if none.
  always_comb begin
    rr_sel = rr_ptr;
    found  = 1'b0;
    idx    = rr_ptr;
    for (int i = 0; i < 8; i++) begin
      idx = rr_ptr + 3'(i);
      if (!found && out_ready[idx]) begin
        rr_sel = idx;
        found  = 1'b1;
      end
    end
  end

  assign nsel      = mode ? rr_sel : in_dest;
  assign ready_sel = out_ready[sel];
  assign tmo       = (TIMEOUT > 0) && (wait_cnt == LAST);

  // Completion frees the slot in the same cycle, so out_ready feeds in_ready.
  assign in_ready = !rst &&
                    ((state == IDLE) ||
                     ((state == BUSY) && ready_sel));

  assign cap    = in_valid && in_ready;
  assign done   = (state == BUSY) && ready_sel && !cap;
  assign expire = (state == BUSY) && !ready_sel && tmo;
  assign stall  = (state == BUSY) && !ready_sel && !tmo;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      out_valid  <= '0;
      out_data   <= '0;
      sel        <= '0;
      busy       <= 1'b0;
      drop       <= 1'b0;
      drop_count <= '0;
      rr_ptr     <= '0;
      wait_cnt   <= '0;
    end else begin
      drop <= 1'b0;
      unique case (1'b1)
        cap: begin
          state     <= BUSY;
          out_data  <= in_data;
          sel       <= nsel;
          out_valid <= 8'd1 << nsel;
          busy      <= 1'b1;
          wait_cnt  <= '0;
          if (mode) rr_ptr <= nsel + 3'd1;
        end
        done: begin
          state     <= IDLE;
          out_valid <= '0;
          busy      <= 1'b0;
        end
        expire: begin
          state     <= DROP;
          out_valid <= '0;
          busy      <= 1'b0;
          drop      <= 1'b1;
          if (drop_count != 8'hFF)
            drop_count <= drop_count + 8'd1;
        end
        stall: begin
          wait_cnt <= wait_cnt + 1'b1;
        end
        (state == DROP): begin
          state <= IDLE;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_demux8_dispatch.sv
// tb_demux8_dispatch: directed bench for demux8_dispatch with TIMEOUT=4.
// Covers addressed, round-robin, back-to-back, timeout, reset and saturation.
module tb_demux8_dispatch;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [2:0] in_dest;
  logic       mode;
  logic [7:0] out_valid;
  logic [7:0] out_ready;
  logic [7:0] out_data;
  logic [2:0] sel;
  logic       busy;
  logic       drop;
  logic [7:0] drop_count;

  int n_cmp;
  int n_bad;

  demux8_dispatch #(
    .DW(8),
    .TIMEOUT(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_dest(in_dest),
    .mode(mode),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .sel(sel),
    .busy(busy),
    .drop(drop),
    .drop_count(drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_dest   = '0;
    mode      = 1'b0;
    out_ready = '0;
    tick();
    tick();
    chk("rst_ovalid", out_valid, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_drop", drop, 1'b0);
    chk("rst_dcnt", drop_count, 8'd0);
    chk("rst_sel", sel, 3'd0);
    chk("rst_odata", out_data, 8'h00);
    chk("rst_irdy", in_ready, 1'b0);
    rst = 1'b0;
    #1;
    chk("idle_irdy", in_ready, 1'b1);

    // addressed
    mode      = 1'b0;
    in_dest   = 3'd5;
    in_data   = 8'hA5;
    out_ready = 8'hFF;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("addr_ovalid", out_valid, 8'h20);
    chk("addr_odata", out_data, 8'hA5);
    chk("addr_sel", sel, 3'd5);
    chk("addr_busy", busy, 1'b1);
    chk("addr_irdy", in_ready, 1'b1);
    tick();
    chk("addr_idle_ov", out_valid, 8'h00);
    chk("addr_idle_busy", busy, 1'b0);

    // round-robin with skip and wrap
    mode      = 1'b1;
    out_ready = 8'b0000_1100;
    in_valid  = 1'b1;
    in_data   = 8'h01;
    tick();
    chk("rr1_sel", sel, 3'd2);
    chk("rr1_ov", out_valid, 8'h04);
    in_data = 8'h02;
    tick();
    chk("rr2_sel", sel, 3'd3);
    chk("rr2_ov", out_valid, 8'h08);
    in_data = 8'h03;
    tick();
    chk("rr3_sel", sel, 3'd2);
    chk("rr3_ov", out_valid, 8'h04);
    chk("rr3_odata", out_data, 8'h03);
    in_valid = 1'b0;
    tick();
    chk("rr_idle", busy, 1'b0);
    // none ready: falls back to rr_ptr, which should be 3
    out_ready = 8'h00;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("rr_ptr3", sel, 3'd3);
    chk("rr_hold_irdy", in_ready, 1'b0);
    out_ready = 8'h08;
    tick();
    chk("rr_ptr_idle", busy, 1'b0);

    // back-to-back addressed
    mode      = 1'b0;
    out_ready = 8'hFF;
    in_valid  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_dest = 3'(k);
      in_data = 8'h10 + 8'(k);
      #1;
      chk($sformatf("b2b_irdy%0d", k), in_ready, 1'b1);
      tick();
      chk($sformatf("b2b_ov%0d", k), out_valid, 8'd1 << k);
      chk($sformatf("b2b_od%0d", k), out_data, 8'h10 + 8'(k));
    end
    in_valid = 1'b0;
    tick();
    chk("b2b_idle", out_valid, 8'h00);

    // timeout on channel 7
    in_dest   = 3'd7;
    in_data   = 8'h77;
    out_ready = 8'h7F;
    in_valid  = 1'b1;
    tick();
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("to_ov%0d", c), out_valid, 8'h80);
      chk($sformatf("to_nodrop%0d", c), drop, 1'b0);
      if (c == 0) in_valid = 1'b0;
      tick();
    end
    chk("to_drop", drop, 1'b1);
    chk("to_ov_drop", out_valid, 8'h00);
    chk("to_busy_drop", busy, 1'b0);
    in_valid = 1'b1;
    #1;
    chk("to_irdy_drop", in_ready, 1'b0);
    in_valid = 1'b0;
    chk("to_dcnt", drop_count, 8'd1);
    tick();
    chk("to_drop_end", drop, 1'b0);
    chk("to_idle_irdy", in_ready, 1'b1);

    // ready arrives in the last offered cycle: completes, no drop
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    chk("late_ov", out_valid, 8'h80);
    out_ready = 8'hFF;
    tick();
    chk("late_drop", drop, 1'b0);
    chk("late_ov_idle", out_valid, 8'h00);
    chk("late_dcnt", drop_count, 8'd1);

    // reset while offering to channel 4
    in_dest   = 3'd4;
    out_ready = 8'h00;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("mrst_ov", out_valid, 8'h10);
    rst = 1'b1;
    tick();
    chk("mrst_ov0", out_valid, 8'h00);
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_drop", drop, 1'b0);
    chk("mrst_dcnt", drop_count, 8'd0);
    rst = 1'b0;
    mode     = 1'b1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("mrst_rrptr", sel, 3'd0);
    out_ready = 8'h01;
    tick();
    chk("mrst_idle", busy, 1'b0);

    // saturation
    mode      = 1'b0;
    in_dest   = 3'd7;
    out_ready = 8'h00;
    for (int n = 1; n <= 260; n++) begin
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (5) tick();
      if (n == 254) chk("sat_254", drop_count, 8'd254);
      if (n == 255) chk("sat_255", drop_count, 8'd255);
    end
    chk("sat_260", drop_count, 8'd255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
